// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: operand width,
// ALU opcodes, response-slot states and the request bundle.
package alu_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int OP_WIDTH   = 4;
  localparam int SHAMT_W    = 5;

  localparam logic [OP_WIDTH-1:0] OP_SUB      = 4'b0001;
  localparam logic [OP_WIDTH-1:0] OP_OR       = 4'b0010;
  localparam logic [OP_WIDTH-1:0] OP_ADD      = 4'b0011;
  localparam logic [OP_WIDTH-1:0] OP_LUI      = 4'b0100;
  localparam logic [OP_WIDTH-1:0] OP_SLL      = 4'b0101;
  localparam logic [OP_WIDTH-1:0] OP_SRL      = 4'b0110;
  localparam logic [OP_WIDTH-1:0] OP_AND      = 4'b0111;
  localparam logic [OP_WIDTH-1:0] OP_NOR      = 4'b1000;
  localparam logic [OP_WIDTH-1:0] OP_NOTHING  = 4'b1010;
  localparam logic [OP_WIDTH-1:0] OP_NOTANDPC = 4'b1011;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic [OP_WIDTH-1:0]   op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [SHAMT_W-1:0]    shamt;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU; unknown opcodes yield zero.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [SHAMT_W-1:0]    shamt_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  topc_o
);

  logic [DATA_WIDTH-1:0] result_s;

  // Operation decode
  always_comb begin
    result_s = {DATA_WIDTH{1'b0}};
    case (op_i)
      OP_SUB:      result_s = a_i - b_i;
      OP_OR:       result_s = a_i | b_i;
      OP_ADD:      result_s = a_i + b_i;
      OP_LUI:      result_s = {b_i[15:0], 16'h0000};
      OP_SLL:      result_s = b_i << shamt_i;
      OP_SRL:      result_s = b_i >> shamt_i;
      OP_AND:      result_s = a_i & b_i;
      OP_NOR:      result_s = ~(a_i | b_i);
      OP_NOTHING:  result_s = a_i;
      OP_NOTANDPC: result_s = a_i;
      default:     result_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign result_o = result_s;
  assign zero_o   = (result_s == {DATA_WIDTH{1'b0}});
  assign topc_o   = (op_i == OP_NOTANDPC);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// single registered response slot that supports one result per cycle.
module alu_arbiter #(
  parameter int DATA_WIDTH = alu_arbiter_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [3:0]            req0_op_i,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  input  logic [4:0]            req0_shamt_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [3:0]            req1_op_i,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  input  logic [4:0]            req1_shamt_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_id_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_zero_o,
  output logic                  rsp_topc_o
);

  import alu_arbiter_pkg::*;

  rsp_state_e            state_q, state_d;
  logic                  last_q, last_d;   // requester granted most recently
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  id_q, id_d;
  logic                  zero_q, zero_d;
  logic                  topc_q, topc_d;

  logic                  slot_free_s;
  logic                  gnt0_s, gnt1_s, accept_s;
  alu_req_t              req0_s, req1_s, sel_req_s;
  logic [DATA_WIDTH-1:0] alu_result_s;
  logic                  alu_zero_s, alu_topc_s;

  assign req0_s = '{op: req0_op_i, a: req0_a_i, b: req0_b_i, shamt: req0_shamt_i};
  assign req1_s = '{op: req1_op_i, a: req1_a_i, b: req1_b_i, shamt: req1_shamt_i};

  // Grant depends only on valids, pointer, slot occupancy and reset
  always_comb begin
    slot_free_s = (state_q == ST_EMPTY) || rsp_ready_i;
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    if (!reset || !slot_free_s) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_valid_i && req1_valid_i) begin
      gnt0_s = last_q;
      gnt1_s = !last_q;
    end else begin
      gnt0_s = req0_valid_i;
      gnt1_s = req1_valid_i;
    end
  end

  assign accept_s  = gnt0_s || gnt1_s;
  assign sel_req_s = gnt1_s ? req1_s : req0_s;

  alu_arbiter_alu u_alu (
    .op_i     (sel_req_s.op),
    .a_i      (sel_req_s.a),
    .b_i      (sel_req_s.b),
    .shamt_i  (sel_req_s.shamt),
    .result_o (alu_result_s),
    .zero_o   (alu_zero_s),
    .topc_o   (alu_topc_s)
  );

  // Slot FSM, pointer and result capture
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    id_d    = id_q;
    zero_d  = zero_q;
    topc_d  = topc_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          state_d = ST_FULL;
        end else if (rsp_ready_i) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (accept_s) begin
      last_d = gnt1_s;
      data_d = alu_result_s;
      id_d   = gnt1_s;
      zero_d = alu_zero_s;
      topc_d = alu_topc_s;
    end else begin
      last_d = last_q;
    end
  end

  // State registers; reset leaves the pointer favouring requester 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      last_q  <= 1'b1;
      data_q  <= {DATA_WIDTH{1'b0}};
      id_q    <= 1'b0;
      zero_q  <= 1'b0;
      topc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      id_q    <= id_d;
      zero_q  <= zero_d;
      topc_q  <= topc_d;
    end
  end

  assign req0_ready_o = gnt0_s;
  assign req1_ready_o = gnt1_s;
  assign rsp_valid_o  = (state_q == ST_FULL);
  assign rsp_id_o     = id_q;
  assign rsp_data_o   = data_q;
  assign rsp_zero_o   = zero_q;
  assign rsp_topc_o   = topc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbiter and response slot.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
  logic [3:0]  req0_op_i, req1_op_i;
  logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic [4:0]  req0_shamt_i, req1_shamt_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o, rsp_topc_o;
  logic [31:0] rsp_data_o;

  int errors = 0;
  int checks = 0;

  // model state
  bit        m_valid, m_id, m_zero, m_topc, m_rst;
  bit [31:0] m_data;
  bit        m_last;
  bit        stuck0, stuck1;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_shamt_i(req0_shamt_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_shamt_i(req1_shamt_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o), .rsp_topc_o(rsp_topc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_alu(input bit [3:0] op, input bit [31:0] a,
                                        input bit [31:0] b, input bit [4:0] sh);
    case (op)
      4'd1:    return a - b;
      4'd2:    return a | b;
      4'd3:    return a + b;
      4'd4:    return b * 32'd65536;
      4'd5:    return b * (32'd1 << sh);
      4'd6:    return b / (32'd1 << sh);
      4'd7:    return a & b;
      4'd8:    return ~(a | b);
      4'd10:   return a;
      4'd11:   return a;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: check readies before the edge, update model, check response after.
  task automatic step();
    bit slot, e0, e1;
    #1;
    slot = !m_valid || rsp_ready_i;
    e0 = 1'b0;
    e1 = 1'b0;
    if (reset && slot) begin
      if (req0_valid_i && req1_valid_i) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = req0_valid_i;
        e1 = req1_valid_i;
      end
    end
    check_eq("req0_ready", {31'd0, req0_ready_o}, {31'd0, e0});
    check_eq("req1_ready", {31'd0, req1_ready_o}, {31'd0, e1});
    @(posedge clk);
    if (!reset) begin
      m_valid = 1'b0; m_data = 32'd0; m_id = 1'b0; m_zero = 1'b0; m_topc = 1'b0;
      m_last = 1'b1; m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (e0 || e1) begin
        m_valid = 1'b1;
        m_id    = e1;
        m_last  = e1;
        m_data  = e1 ? ref_alu(req1_op_i, req1_a_i, req1_b_i, req1_shamt_i)
                     : ref_alu(req0_op_i, req0_a_i, req0_b_i, req0_shamt_i);
        m_zero  = (m_data == 32'd0);
        m_topc  = e1 ? (req1_op_i == 4'd11) : (req0_op_i == 4'd11);
      end else if (rsp_ready_i) begin
        m_valid = 1'b0;
      end
    end
    stuck0 = reset && req0_valid_i && !e0;
    stuck1 = reset && req1_valid_i && !e1;
    #1;
    check_eq("rsp_valid", {31'd0, rsp_valid_o}, {31'd0, m_valid});
    if (m_valid || m_rst) begin
      check_eq("rsp_data", rsp_data_o, m_data);
      check_eq("rsp_id",   {31'd0, rsp_id_o},   {31'd0, m_id});
      check_eq("rsp_zero", {31'd0, rsp_zero_o}, {31'd0, m_zero});
      check_eq("rsp_topc", {31'd0, rsp_topc_o}, {31'd0, m_topc});
    end
  endtask

  task automatic idle_inputs();
    req0_valid_i = 1'b0; req0_op_i = 4'd0; req0_a_i = 32'd0; req0_b_i = 32'd0; req0_shamt_i = 5'd0;
    req1_valid_i = 1'b0; req1_op_i = 4'd0; req1_a_i = 32'd0; req1_b_i = 32'd0; req1_shamt_i = 5'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    step();
    reset = 1'b1;
  endtask

  task automatic rand_req(output logic [3:0] op, output logic [31:0] a,
                          output logic [31:0] b, output logic [4:0] sh);
    logic [3:0] ops [10];
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11};
    if ($urandom_range(0, 9) == 0) op = 4'($urandom);
    else                           op = ops[$urandom_range(0, 9)];
    b  = $urandom;
    a  = ($urandom_range(0, 3) == 0) ? b : $urandom;
    sh = 5'($urandom);
  endtask

  initial begin
    rsp_ready_i = 1'b1;
    m_last = 1'b1;
    reset = 1'b0;
    idle_inputs();
    step();
    step();
    reset = 1'b1;

    // single ADD
    req0_valid_i = 1'b1; req0_op_i = 4'd3; req0_a_i = 32'd5; req0_b_i = 32'd7;
    step();
    check_eq("add_data", rsp_data_o, 32'd12);
    check_eq("add_id",   {31'd0, rsp_id_o}, 32'd0);
    check_eq("add_zero", {31'd0, rsp_zero_o}, 32'd0);

    // conflict right after reset: requester 0 first
    do_reset();
    req0_valid_i = 1'b1; req0_op_i = 4'd1; req0_a_i = 32'd9;    req0_b_i = 32'd9;
    req1_valid_i = 1'b1; req1_op_i = 4'd2; req1_a_i = 32'hF0;   req1_b_i = 32'h0F;
    step();
    check_eq("conf_id0",   {31'd0, rsp_id_o}, 32'd0);
    check_eq("conf_zero0", {31'd0, rsp_zero_o}, 32'd1);
    req0_valid_i = 1'b0;
    step();
    check_eq("conf_data1", rsp_data_o, 32'hFF);
    check_eq("conf_id1",   {31'd0, rsp_id_o}, 32'd1);

    // continuous contention alternates
    do_reset();
    req0_valid_i = 1'b1; req0_op_i = 4'd3; req0_a_i = 32'd1; req0_b_i = 32'd2;
    req1_valid_i = 1'b1; req1_op_i = 4'd3; req1_a_i = 32'd3; req1_b_i = 32'd4;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("rr_id", {31'd0, rsp_id_o}, 32'(i % 2));
      check_eq("rr_valid", {31'd0, rsp_valid_o}, 32'd1);
    end

    // backpressure while full
    req1_valid_i = 1'b0;
    req0_op_i = 4'd3; req0_a_i = 32'd1; req0_b_i = 32'd2;
    step();
    rsp_ready_i = 1'b0; req0_valid_i = 1'b0;
    req1_valid_i = 1'b1; req1_op_i = 4'd7; req1_a_i = 32'hFF00; req1_b_i = 32'h0FF0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_hold_data", rsp_data_o, 32'd3);
      check_eq("bp_ready1", {31'd0, req1_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    #1;
    check_eq("bp_release_ready1", {31'd0, req1_ready_o}, 32'd1);
    step();
    check_eq("bp_release_data", rsp_data_o, 32'h0F00);

    // boundary operations
    req1_op_i = 4'd11; req1_a_i = 32'h0040_0020; req1_b_i = 32'd0;
    step();
    check_eq("pc_data", rsp_data_o, 32'h0040_0020);
    check_eq("pc_topc", {31'd0, rsp_topc_o}, 32'd1);
    req1_valid_i = 1'b0;
    req0_valid_i = 1'b1; req0_op_i = 4'd5; req0_b_i = 32'd1; req0_shamt_i = 5'd31;
    step();
    check_eq("sll31", rsp_data_o, 32'h8000_0000);
    req0_op_i = 4'd3; req0_a_i = 32'hFFFF_FFFF; req0_b_i = 32'd1; req0_shamt_i = 5'd0;
    step();
    check_eq("wrap_data", rsp_data_o, 32'd0);
    check_eq("wrap_zero", {31'd0, rsp_zero_o}, 32'd1);

    // reset while full discards the result
    reset = 1'b0;
    step();
    check_eq("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    check_eq("rst_data",  rsp_data_o, 32'd0);
    reset = 1'b1;
    idle_inputs();
    step();

    // randomized traffic, holding requests that are waiting
    for (int c = 0; c < 500; c++) begin
      if (!stuck0) begin
        req0_valid_i = ($urandom_range(0, 9) < 7);
        rand_req(req0_op_i, req0_a_i, req0_b_i, req0_shamt_i);
      end
      if (!stuck1) begin
        req1_valid_i = ($urandom_range(0, 9) < 7);
        rand_req(req1_op_i, req1_a_i, req1_b_i, req1_shamt_i);
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
